// File: rtl/complex_nr_acc.sv
// Purpose    : accumulates acc_len consecutive complex products {re, im} into widened sums.
// Latency    : out_val rises the cycle after the last beat of a frame; N-beat frame takes N+1 cycles.
// Backpressure: in_ready drops while the sum is presented; out_data holds until out_ready.
//
// Ports: clk/rstn (async, active low), sw_rst (sync, active high), acc_len (0 => 2^LEN_WIDTH),
//        in_val/in_ready/in_data (re in [4DW-1:2DW], im in [2DW-1:0], top 3 bits ignored),
//        out_val/out_ready/out_data ({acc_re, acc_im}), busy (frame in progress).
// Optional: define COMPLEX_NR_ACC_LAST_EN to add in_last, which ends a frame early.
module complex_nr_acc #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_GUARD  = 4,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                                    clk,
   input  logic                                    rstn,
   input  logic                                    sw_rst,
   input  logic [LEN_WIDTH-1:0]                    acc_len,
   input  logic                                    in_val,
   output logic                                    in_ready,
   input  logic [4*DATA_WIDTH+2:0]                 in_data,
`ifdef COMPLEX_NR_ACC_LAST_EN
   input  logic                                    in_last,
`endif
   input  logic                                    out_ready,
   output logic                                    out_val,
   output logic [2*(2*DATA_WIDTH+ACC_GUARD)-1:0]   out_data,
   output logic                                    busy
);

   localparam int PW    = 2 * DATA_WIDTH;
   localparam int ACC_W = PW + ACC_GUARD;
   // One extra bit so the 2^LEN_WIDTH frame length is representable.
   localparam int CW    = LEN_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [ACC_W-1:0]   acc_re, acc_im;
   logic [CW-1:0]      cnt, len_q;
   logic [CW-1:0]      len_new, cnt_inc;
   logic [ACC_W-1:0]   samp_re, samp_im;
   logic               accept;
   logic               last_beat;
   logic               unused_tag;

   // Sign-extend each product field to the accumulator width.
   assign samp_re = {{ACC_GUARD{in_data[2*PW-1]}}, in_data[2*PW-1:PW]};
   assign samp_im = {{ACC_GUARD{in_data[PW-1]}},   in_data[PW-1:0]};
   assign unused_tag = ^in_data[4*DATA_WIDTH+2:4*DATA_WIDTH];

   assign accept  = in_val & in_ready;
   assign len_new = (acc_len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, acc_len};
   assign cnt_inc = cnt + CW'(1);

`ifdef COMPLEX_NR_ACC_LAST_EN
   assign last_beat = in_last;
`else
   assign last_beat = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_val   = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (accept) begin
               // Frame length comes from acc_len as sampled on this first beat.
               if (len_new == CW'(1) || last_beat) begin
                  state_nxt = OUT;
               end else begin
                  state_nxt = ACC;
               end
            end
         end
         ACC: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (accept && (cnt_inc == len_q || last_beat)) begin
               state_nxt = OUT;
            end
         end
         OUT: begin
            out_val = 1'b1;
            busy    = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (sw_rst) begin
         state_nxt = IDLE;
      end
   end

   // Accumulators double as the output register: no accept happens in OUT,
   // so the sum stays stable while out_val waits for out_ready.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_re <= '0;
         acc_im <= '0;
         cnt    <= '0;
         len_q  <= '0;
      end else if (sw_rst) begin
         acc_re <= '0;
         acc_im <= '0;
         cnt    <= '0;
         len_q  <= '0;
      end else if (accept) begin
         if (state == IDLE) begin
            acc_re <= samp_re;
            acc_im <= samp_im;
            cnt    <= CW'(1);
            len_q  <= len_new;
         end else begin
            acc_re <= acc_re + samp_re;
            acc_im <= acc_im + samp_im;
            cnt    <= cnt_inc;
         end
      end
   end

   assign out_data = {acc_re, acc_im};

endmodule

// File: tb/tb_complex_nr_acc.sv
module tb_complex_nr_acc;

   localparam int DW = 8;
   localparam int AW = 2 * DW + 4;

   logic              clk;
   logic              rstn;
   logic              sw_rst;
   logic [3:0]        acc_len;
   logic              in_val;
   logic              in_ready;
   logic [4*DW+2:0]   in_data;
   logic              in_last;
   logic              out_ready;
   logic              out_val;
   logic [2*AW-1:0]   out_data;
   logic              busy;

   int errors = 0;
   int checks = 0;
   logic [2*AW-1:0] got_q[$];

   complex_nr_acc #(.DATA_WIDTH(DW), .ACC_GUARD(4), .LEN_WIDTH(4)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .sw_rst    (sw_rst),
      .acc_len   (acc_len),
      .in_val    (in_val),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef COMPLEX_NR_ACC_LAST_EN
      .in_last   (in_last),
`endif
      .out_ready (out_ready),
      .out_val   (out_val),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change at posedge+1, so a handshake visible at the negedge completes on the next posedge.
   always @(negedge clk) begin
      if (rstn && !sw_rst && out_val && out_ready) got_q.push_back(out_data);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat and returns just after the edge on which it was accepted.
   task automatic send_beat(input logic [15:0] re, input logic [15:0] im, input bit last);
      int n = 0;
      bit acc = 0;
      in_val  = 1'b1;
      in_data = {3'($urandom_range(0, 7)), re, im};
      in_last = last;
      while (!acc && n < 64) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         n++;
      end
      in_val  = 1'b0;
      in_last = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL send_beat: beat not accepted within %0d cycles (got in_ready=%b, need 1)", n, in_ready);
      end
   endtask

   task automatic wait_out(input string name);
      int n = 0;
      while (got_q.size() == 0 && n < 200) begin
         tick();
         n++;
      end
      if (got_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no output within 200 cycles (got none, need one)", name);
      end
   endtask

   function automatic logic [2*AW-1:0] pack_sum(input int sre, input int sim);
      logic [AW-1:0] r;
      logic [AW-1:0] i;
      r = AW'(sre);
      i = AW'(sim);
      return {r, i};
   endfunction

   task automatic check_out(input string name, input logic [2*AW-1:0] exp);
      logic [2*AW-1:0] got;
      wait_out(name);
      if (got_q.size() != 0) begin
         got = got_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s: out_data got=%h need=%h", name, got, exp);
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; sw_rst = 1'b0; acc_len = 4'd0; in_val = 1'b0;
      in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      rstn = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b need=1", in_ready); end
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got=%b need=0", out_val); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b need=0", busy); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h need=0", out_data); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      acc_len = 4'd3;
      send_beat(16'd100, 16'd200, 1'b0);
      send_beat(16'hFFCE, 16'd10, 1'b0);
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL basic_early got out_val=%b need=0", out_val); end
      send_beat(16'd5, 16'd5, 1'b0);
      checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL basic_latency got out_val=%b need=1", out_val); end
      checks++; if (out_data !== {20'h00037, 20'h000D7}) begin errors++; $display("FAIL basic_data got=%h need=%h", out_data, {20'h00037, 20'h000D7}); end
      tick();
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got out_val=%b need=0", out_val); end
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL basic_count got=%0d outputs need=1", got_q.size()); end
      got_q.delete();
   endtask

   task automatic test_extremes();
      acc_len = 4'd0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) send_beat(16'h8000, 16'h7FFF, 1'b0);
      check_out("extremes", {20'h80000, 20'h7FFF0});
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      acc_len = 4'd1;
      send_beat(16'd7, 16'hFFFF, 1'b0);
      in_val = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL bp_out_val cyc%0d got=%b need=1", i, out_val); end
         checks++; if (out_data !== {20'h00007, 20'hFFFFF}) begin errors++; $display("FAIL bp_data cyc%0d got=%h need=%h", i, out_data, {20'h00007, 20'hFFFFF}); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got=%b need=0", i, in_ready); end
         tick();
      end
      in_val = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++; if (out_val !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release got val/busy/rdy=%b%b%b need=001", out_val, busy, in_ready);
      end
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL bp_count got=%0d outputs need=1", got_q.size()); end
      got_q.delete();
   endtask

   task automatic test_abort();
      out_ready = 1'b1;
      acc_len = 4'd4;
      send_beat(16'd11, 16'd22, 1'b0);
      send_beat(16'd33, 16'd44, 1'b0);
      sw_rst = 1'b1;
      tick();
      sw_rst = 1'b0;
      checks++; if (busy !== 1'b0 || out_val !== 1'b0) begin
         errors++; $display("FAIL abort_state got busy/val=%b%b need=00", busy, out_val);
      end
      repeat (4) tick();
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL abort_no_out got=%0d outputs need=0", got_q.size()); end
      acc_len = 4'd1;
      send_beat(16'd3, 16'd4, 1'b0);
      check_out("abort_new_frame", {20'h00003, 20'h00004});
      // Async reset while the sum is waiting for the consumer.
      out_ready = 1'b0;
      send_beat(16'd9, 16'd9, 1'b0);
      rstn = 1'b0;
      #1;
      checks++; if (out_val !== 1'b0 || out_data !== '0) begin
         errors++; $display("FAIL rstn_in_out got val=%b data=%h need 0/0", out_val, out_data);
      end
      @(negedge clk);
      rstn = 1'b1;
      out_ready = 1'b1;
      repeat (3) tick();
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstn_no_out got=%0d outputs need=0", got_q.size()); end
   endtask

   task automatic test_random();
      for (int f = 0; f < 15; f++) begin
         int len;
         int n;
         int cut;
         int sre = 0;
         int sim = 0;
         logic [15:0] re;
         logic [15:0] im;
         len = $urandom_range(0, 15);
         n = (len == 0) ? 16 : len;
         cut = n;
`ifdef COMPLEX_NR_ACC_LAST_EN
         if ($urandom_range(0, 3) == 0) cut = $urandom_range(1, n);
`endif
         acc_len = 4'(len);
         out_ready = 1'($urandom_range(0, 1));
         for (int b = 0; b < cut; b++) begin
            re = 16'($urandom);
            im = 16'($urandom);
            sre += int'($signed(re));
            sim += int'($signed(im));
            send_beat(re, im, (b == cut - 1) && (cut != n));
            // Later acc_len values must not affect the frame in flight.
            acc_len = 4'($urandom);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) tick();
         end
         for (int c = 0; c < 100 && got_q.size() == 0; c++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
         end
         out_ready = 1'b1;
         check_out($sformatf("random_frame%0d", f), pack_sum(sre, sim));
         tick();
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL random_idle%0d got busy=%b need=0", f, busy); end
      end
   endtask

`ifdef COMPLEX_NR_ACC_LAST_EN
   task automatic test_last();
      out_ready = 1'b1;
      acc_len = 4'd8;
      send_beat(16'd1, 16'd1, 1'b0);
      send_beat(16'd2, 16'd2, 1'b1);
      checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL last_latency got out_val=%b need=1", out_val); end
      check_out("last_two", {20'h00003, 20'h00003});
      tick();
      send_beat(16'd5, 16'hFFFD, 1'b1);
      check_out("last_first", {20'h00005, 20'hFFFFD});
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_backpressure();
      test_abort();
`ifdef COMPLEX_NR_ACC_LAST_EN
      test_last();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/complex_nr_acc.md
Name: complex_nr_acc

Overview:
- Downstream stage of the complex number multiplier. Consumes its result stream {re, im}.
- Accumulates a programmable number of consecutive complex products into widened real and imaginary accumulators.
- Presents the complex sum on a registered val/ready output.
- Used to build complex dot products / correlations from the multiplier's product stream.

Parameters:
- DATA_WIDTH, 8, operand width of the upstream multiplier; each product field is 2*DATA_WIDTH bits.
- ACC_GUARD, 4, guard bits; ACC_W = 2*DATA_WIDTH+ACC_GUARD.
- LEN_WIDTH, 4, width of the frame-length input; ACC_GUARD >= LEN_WIDTH guarantees no overflow.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous reset, active 0
- sw_rst  input  1  software reset, active 1, synchronous
- acc_len  input  LEN_WIDTH  products per frame; 0 means 2^LEN_WIDTH
- in_val  input  1  product valid (driven by multiplier res_val)
- in_ready  output  1  block can accept a product (drives multiplier res_ready)
- in_data  input  4*DATA_WIDTH+3  product; [4DW-1:2DW]=re, [2DW-1:0]=im; bits [4DW+2:4DW] ignored
- out_ready  input  1  consumer ready
- out_val  output  1  accumulated sum valid
- out_data  output  2*ACC_W  {acc_re, acc_im}, two's complement
- busy  output  1  a frame is in progress (state != IDLE)

Behaviour:
- Single clock domain.
- Reset is asynchronous and active-low on rstn.
- sw_rst has the same effect as rstn, applied synchronously; it has priority over all other activity in the cycle.
- Reset values:
  - state = IDLE
  - in_ready = 1, out_val = 0, busy = 0
  - out_data = 0, acc_re = acc_im = 0, cnt = 0
- Field handling: re and im are each 2*DATA_WIDTH-bit two's complement, sign-extended to ACC_W before adding.
- Accumulator width makes overflow impossible for up to 2^LEN_WIDTH terms; arithmetic is otherwise modulo 2^ACC_W.
- A beat is accepted when in_val & in_ready.
- State IDLE:
  - in_ready = 1.
  - On accept: acc <- sign-extended sample; cnt <- 1; len_q <- acc_len, with 0 mapped to 2^LEN_WIDTH.
  - If len_q == 1, go to OUT; otherwise go to ACC.
- State ACC:
  - in_ready = 1.
  - On accept: acc <- acc + sample; cnt <- cnt + 1.
  - If cnt+1 == len_q, go to OUT.
  - No accept: hold all state.
- State OUT:
  - in_ready = 0; out_val = 1; out_data = {acc_re, acc_im}, stable while out_val & ~out_ready.
  - On out_ready, go to IDLE; the next frame starts no earlier than the following cycle.
- Latency: out_val rises on the cycle after the last beat of the frame is accepted.
- Throughput: one bubble cycle per frame, minimum. Frame of N beats occupies N+1 cycles when in_val and out_ready are held at 1.
- acc_len is sampled only on the first accepted beat. Changes mid-frame have no effect on the current frame.
- in_val low mid-frame: state and count hold indefinitely; there is no timeout.
- rstn or sw_rst mid-frame or during OUT: partial sum discarded, out_val drops, no output produced.
- in_ready is combinational from state only; it never depends on in_val.
- busy = 1 in ACC and OUT.

Optional Feature:
- Macro: COMPLEX_NR_ACC_LAST_EN.
- Defined:
  - Adds input port in_last (1 bit), sampled with in_data on accept.
  - A frame terminates on the accepted beat where in_last=1 or cnt reaches len_q, whichever is first.
  - in_last=1 on the first beat gives a 1-term frame.
- Undefined:
  - Port absent; frames end only on the count.

Test Plan:
- Reset/idle: rstn=0 then 1, no stimulus -> in_ready=1, out_val=0, busy=0, out_data=0.
- Basic frame, DW=8: acc_len=3; beats (re,im) = (100,200), (0xFFCE=-50,10), (5,5), in_val continuous, out_ready=1 -> out_val on cycle 4 for exactly one cycle; out_data={20'h00037, 20'h000D7}.
- Extremes: acc_len=0 (16 terms); 16 beats of re=0x8000, im=0x7FFF -> acc_re=20'h80000 (-524288), acc_im=20'h7FFF0; no wrap.
- Backpressure: acc_len=1, beat (7,-1); out_ready held 0 for 5 cycles -> out_val=1 and out_data={20'h00007, 20'hFFFFF} stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
- Mid-frame abort: acc_len=4, accept 2 beats, pulse sw_rst 1 cycle -> no out_val; a new frame (acc_len=1, beat (3,4)) yields {20'h3, 20'h4}.
- With COMPLEX_NR_ACC_LAST_EN: acc_len=8; beats (1,1), (2,2) with in_last=1 on the second -> out_data={20'h3, 20'h3} after 2 beats.
